// File: rtl/vx_gpu_pkg.sv
// vx_gpu_pkg: commit payload type shared by the execute units and the commit arbiter
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
package vx_gpu_pkg;
  localparam int NUM_THREADS = `NUM_THREADS;
  typedef struct packed {
    logic [31:0]               uuid;
    logic [1:0]                wid;
    logic [NUM_THREADS-1:0]    tmask;
    logic [31:0]               pc;
    logic                      wb;
    logic [4:0]                rd;
    logic [NUM_THREADS*32-1:0] data;
    logic                      sop;
    logic                      eop;
  } commit_data_t;
  localparam int COMMIT_DATAW = $bits(commit_data_t);
endpackage

// File: rtl/vx_commit_rr_arb.sv
// vx_commit_rr_arb: round-robin commit grant that stays locked on a source until its eop packet is taken
module vx_commit_rr_arb #(
  parameter int N = 4,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  valid,
  input  logic          fire,
  input  logic          eop,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr, lock_idx;
  logic lock, found;
  always_comb begin
    idx = lock_idx;
    found = lock;
    for (int k = 0; k < N; k++) begin
      if (!found && valid[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
        found = 1'b1;
      end
    end
    grant = '0;
    grant[idx] = found;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      lock <= 1'b0;
      lock_idx <= '0;
    end else if (fire) begin
      ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
      lock <= !eop;
      lock_idx <= idx;
    end
  end
endmodule

// File: rtl/vx_commit_arb.sv
// vx_commit_arb: arbitrates execute-unit commits into a 2-entry writeback FIFO.
// VX_COMMIT_PERF_EN adds the commit_cnt committed-thread counter.
module vx_commit_arb
  import vx_gpu_pkg::*;
#(
  parameter int NUM_SRCS  = 4,
  parameter int NUM_LANES = `NUM_THREADS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_SRCS-1:0]              in_valid,
  output logic [NUM_SRCS-1:0]              in_ready,
  input  logic [NUM_SRCS*COMMIT_DATAW-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [COMMIT_DATAW-1:0]          out_data
`ifdef VX_COMMIT_PERF_EN
  ,
  output logic [63:0]                      commit_cnt
`endif
);
  localparam int IW = NUM_SRCS > 1 ? $clog2(NUM_SRCS) : 1;
  if (NUM_LANES != NUM_THREADS) begin : g_bad_lanes
    $error("NUM_LANES must equal NUM_THREADS");
  end
  logic [NUM_SRCS-1:0] grant;
  logic [IW-1:0] idx;
  commit_data_t sel, head;
  commit_data_t mem [2];
  logic rd_ptr, wr_ptr, push, pop;
  logic [1:0] occ;
  vx_commit_rr_arb #(.N(NUM_SRCS)) arb (
    .clk(clk), .reset(reset), .valid(in_valid), .fire(push), .eop(sel.eop),
    .grant(grant), .idx(idx)
  );
  assign sel = commit_data_t'(in_data[int'(idx)*COMMIT_DATAW +: COMMIT_DATAW]);
  // Acceptance depends only on FIFO space, never on out_ready
  assign in_ready = (reset && occ != 2'd2) ? grant : '0;
  assign push = |(in_valid & in_ready);
  assign pop = out_valid && out_ready;
  assign head = mem[rd_ptr];
  assign out_valid = occ != 2'd0;
  assign out_data = head;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ <= 2'd0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop) rd_ptr <= !rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= sel;
`ifdef VX_COMMIT_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) commit_cnt <= '0;
    else if (pop && head.eop) commit_cnt <= commit_cnt + 64'($countones(head.tmask[NUM_LANES-1:0]));
  end
`endif
endmodule

// File: tb/tb_vx_commit_arb.sv
// tb_vx_commit_arb: random and directed stimulus checked every cycle against a queue-based model
module tb_vx_commit_arb;
  import vx_gpu_pkg::*;
  localparam int N = 4;
  localparam int W = COMMIT_DATAW;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] in_valid, in_ready;
  logic [N*W-1:0] in_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [W-1:0] out_data;
`ifdef VX_COMMIT_PERF_EN
  logic [63:0] commit_cnt;
`endif
  commit_data_t pend [N];
  logic pend_valid [N];
  commit_data_t m_q [$];
  logic [31:0] out_log [$];
  int m_ptr, m_lsrc, seq, vectors, miscompares;
  bit m_lock;
  logic [63:0] m_cnt;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_valid[i] = pend_valid[i];
      in_data[i*W +: W] = pend[i];
    end
  end

  vx_commit_arb #(.NUM_SRCS(N), .NUM_LANES(NUM_THREADS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef VX_COMMIT_PERF_EN
    , .commit_cnt(commit_cnt)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic refill(input int src, input bit eop, input logic [NUM_THREADS-1:0] tmask);
    commit_data_t p;
    p.uuid = {8'(src), 24'(seq)};
    p.wid = 2'($urandom);
    p.tmask = tmask;
    p.pc = $urandom;
    p.wb = 1'($urandom);
    p.rd = 5'($urandom);
    for (int l = 0; l < NUM_THREADS; l++) p.data[l*32 +: 32] = $urandom;
    p.sop = 1'($urandom);
    p.eop = eop;
    pend[src] = p;
    pend_valid[src] = 1'b1;
    seq++;
  endtask

  // Grant rule: a locked source keeps the grant, otherwise the first valid source from the pointer
  function automatic int m_grant();
    if (m_lock) return m_lsrc;
    for (int k = 0; k < N; k++) if (pend_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic step();
    int g;
    logic [N-1:0] exp_rdy;
    bit fire, pop;
    commit_data_t o;
    @(negedge clk);
    g = m_grant();
    exp_rdy = '0;
    if (g >= 0 && m_q.size() < 2) exp_rdy[g] = 1'b1;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) chk("out_data", out_data, m_q[0]);
`ifdef VX_COMMIT_PERF_EN
    chk("commit_cnt", commit_cnt, m_cnt);
`endif
    fire = g >= 0 && exp_rdy[g] && pend_valid[g];
    pop = m_q.size() > 0 && out_ready;
    o = commit_data_t'(out_data);
    if (out_valid && out_ready) out_log.push_back(o.uuid);
    @(posedge clk);
    #1;
    if (pop) begin
      if (m_q[0].eop) m_cnt += 64'($countones(m_q[0].tmask));
      void'(m_q.pop_front());
    end
    if (fire) begin
      m_q.push_back(pend[g]);
      m_ptr = (g + 1) % N;
      m_lock = !pend[g].eop;
      m_lsrc = g;
      pend_valid[g] = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    out_log.delete();
    m_ptr = 0;
    m_lock = 0;
    m_lsrc = 0;
    m_cnt = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < N; i++) pend_valid[i] = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst_in_ready", in_ready, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    int lk_exp [4] = '{1, 1, 1, 2};
    logic [31:0] a_uuid, b_uuid;
    int n1;
    vectors = 0;
    miscompares = 0;
    seq = 0;
    // Four always-valid single-packet sources rotate 0,1,2,3,0
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) refill(i, 1'b1, '1);
    for (int c = 0; c < 8; c++) begin
      step();
      if (c == 0) chk("latency", out_valid, 1'b1);
      for (int i = 0; i < N; i++) if (!pend_valid[i]) refill(i, 1'b1, '1);
    end
    chk("rr_count", out_log.size(), 7);
    for (int k = 0; k < 5; k++) chk("rr_order", out_log[k][31:24], rr_exp[k]);
    // Multi-packet lock on source 1 blocks source 2
    do_reset();
    out_ready = 1'b1;
    refill(1, 1'b0, '1);
    n1 = 1;
    refill(2, 1'b1, '1);
    for (int c = 0; c < 6; c++) begin
      step();
      if (c < 2) chk("lock_block", in_ready[2], 1'b0);
      if (c == 2) chk("lock_release", in_ready[2], 1'b1);
      if (!pend_valid[1] && n1 < 3) begin
        refill(1, n1 == 2, '1);
        n1++;
      end
    end
    chk("lock_count", out_log.size(), 4);
    for (int k = 0; k < 4; k++) chk("lock_order", out_log[k][31:24], lk_exp[k]);
    // Backpressure fills both entries, then drains in order
    do_reset();
    out_ready = 1'b0;
    refill(0, 1'b1, '1);
    a_uuid = pend[0].uuid;
    b_uuid = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (!pend_valid[0]) begin
        refill(0, 1'b1, '1);
        if (c == 0) b_uuid = pend[0].uuid;
      end
      if (c >= 1) begin
        chk("bp_in_ready", in_ready, '0);
        chk("bp_head", out_data[W-1 -: 32], a_uuid);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (!pend_valid[0]) refill(0, 1'b1, '1);
    end
    chk("bp_first", out_log[0], a_uuid);
    chk("bp_second", out_log[1], b_uuid);
    // Reset while locked with two entries buffered
    do_reset();
    out_ready = 1'b0;
    refill(2, 1'b0, '1);
    step();
    refill(2, 1'b0, '1);
    step();
    refill(0, 1'b1, '1);
    refill(1, 1'b1, '1);
    refill(2, 1'b0, '1);
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, '0);
`ifdef VX_COMMIT_PERF_EN
    chk("midrst_cnt", commit_cnt, '0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    chk("midrst_first", out_log[0][31:24], 0);
`ifdef VX_COMMIT_PERF_EN
    begin
      logic [NUM_THREADS-1:0] tm [4] = '{4'hF, 4'h1, 4'hF, 4'h0};
      bit eo [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      int k;
      do_reset();
      out_ready = 1'b1;
      k = 0;
      for (int c = 0; c < 10; c++) begin
        if (!pend_valid[0] && k < 4) begin
          refill(0, eo[k], tm[k]);
          k++;
        end
        step();
      end
      chk("perf_sum", commit_cnt, 64'd5);
      force dut.commit_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
      #1;
      release dut.commit_cnt;
      m_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
      refill(0, 1'b1, 4'hF);
      for (int c = 0; c < 4; c++) step();
      chk("perf_wrap", commit_cnt, 64'd2);
    end
`endif
    // Random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      out_ready = $urandom_range(3) != 0;
      for (int i = 0; i < N; i++)
        if (!pend_valid[i] && $urandom_range(1) == 1) refill(i, $urandom_range(3) != 0, NUM_THREADS'($urandom));
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vx_commit_arb.md
VX_COMMIT_ARB -- requirements
Module: VX_commit_arb

Interface
REQ-001 SHALL have parameter NUM_SRCS, default 4, giving the number of execute-unit commit sources (ALU, LSU, FPU, SFU order).
REQ-002 SHALL have parameter NUM_LANES, default `NUM_THREADS, giving the thread-mask width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, NUM_SRCS bits: per-source commit valid.
REQ-006 SHALL have port in_ready, output, NUM_SRCS bits: per-source commit accept.
REQ-007 SHALL have port in_data, input, NUM_SRCS*COMMIT_DATAW bits: per-source commit_data_t payload (uuid, wid, tmask, PC, wb, rd, data, sop, eop).
REQ-008 SHALL have port out_valid, output, 1 bit: writeback valid.
REQ-009 SHALL have port out_ready, input, 1 bit: writeback accept.
REQ-010 SHALL have port out_data, output, COMMIT_DATAW bits: selected payload.
REQ-011 SHALL have port commit_cnt, output, 64 bits: committed-thread count (present only under VX_COMMIT_PERF_EN).

Function
REQ-012 Transfer occurs on valid&&ready at the rising clk edge on both sides.
REQ-013 Grant SHALL be round-robin: the highest priority goes to the source after the last granted source; after reset, source 0 has the highest priority.
REQ-014 A granted packet with eop=0 SHALL lock the grant to that source until its eop=1 packet is accepted; while locked, other sources see in_ready=0.
REQ-015 in_ready[i] SHALL be grant[i] && (buffer occupancy < 2), combinational; it SHALL NOT depend on out_ready.
REQ-016 The output buffer SHALL be a 2-entry FIFO; out_valid=(occupancy>0); out_data=head entry, held stable while out_valid&&!out_ready.
REQ-017 Latency from input acceptance to out_valid SHALL be 1 cycle into an empty buffer.
REQ-018 Sustained throughput SHALL be 1 packet/cycle with out_ready held high.
REQ-019 Simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1; at occupancy 2, only a pop is possible.
REQ-020 When in_valid=0 on all sources, the grant pointer and lock SHALL hold.
REQ-021 Packets from one source SHALL leave in acceptance order; no packet is dropped or duplicated.

Reset
REQ-022 On reset low, asynchronously: out_valid=0, occupancy=0, lock cleared, grant pointer=0, commit_cnt=0; in_ready=0 while reset is asserted.
REQ-023 Reset asserted mid-packet (locked) SHALL discard buffered entries and the lock; after release, arbitration restarts from source 0.

Configuration
REQ-024 Macro VX_COMMIT_PERF_EN defined: commit_cnt SHALL add popcount(tmask) on each out handshake with eop=1, wrapping modulo 2^64.
REQ-025 Macro VX_COMMIT_PERF_EN undefined: the commit_cnt port and the counter logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-026 commit_data_t and COMMIT_DATAW SHALL reside in VX_gpu_pkg.
REQ-027 The round-robin/lock arbiter SHALL be the sub-module VX_commit_rr_arb; the FIFO and counter SHALL be inline.

Verification
REQ-028 All 4 sources valid continuously, eop=1, out_ready=1 -> grant order 0,1,2,3,0; one output per cycle from cycle 1.
REQ-029 Source 1 sends 3 packets (eop only on the 3rd) while source 2 is valid -> outputs are 1,1,1 then 2; in_ready[2]=0 during the lock.
REQ-030 out_ready=0 for 5 cycles with source 0 valid -> 2 packets buffered, in_ready=0 from cycle 2, out_data stable; out_ready=1 -> both drain in order.
REQ-031 Under VX_COMMIT_PERF_EN: 3 eop commits with tmask 0xF, 0x1, 0x0 and 1 non-eop commit with tmask 0xF -> commit_cnt=5.
REQ-032 Reset pulsed while locked with 2 entries buffered -> out_valid=0 immediately and commit_cnt=0; after release, source 0 wins first.
REQ-033 commit_cnt preloaded by force to 2^64-2, then an eop commit with tmask 0xF -> commit_cnt=2.
